instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Fetch front-end between the instruction memory port and the IF/ID pipeline register.
- Owns the fetch PC and issues word reads to instruction memory.
- Buffers up to DEPTH returned instructions, each tagged with its PC+4.
- Presents the oldest entry to IF/ID with a valid/ready handshake. On a branch/jump redirect it flushes and refetches from the target.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-low reset.
- redirect  in  1  taken branch/jump from MEM stage; single-cycle pulse.
- redirect_pc  in  32  target PC, valid when redirect=1.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  32  word-aligned read address.
- mem_valid  in  1  read data valid; arrives exactly 1 cycle after mem_req.
- mem_rdata  in  32  instruction word.
- deq_ready  in  1  IF/ID can accept (low = stall).
- instr_valid  out  1  head entry valid.
- instr_out  out  32  head instruction; 32'd0 (NOP) when instr_valid=0.
- pc_out  out  32  head PC+4; 0 when instr_valid=0.
- q_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0 at clk edge):
  - fetch_pc=RESET_PC; queue emptied; rd/wr pointers=0; q_count=0.
  - inflight=0; state=S_IDLE.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=0.
  - Reset mid-operation discards everything, including a response due next cycle.
- States:
  - S_IDLE: one cycle after reset, no issue. Always goes to S_RUN.
  - S_RUN: normal fetch.
  - S_FLUSH: exactly one cycle following a redirect that had a request in flight. The mem_valid response arriving in this cycle is dropped. Issue is allowed. Goes to S_RUN, or stays in S_FLUSH if another redirect arrives with a request in flight.
- Issue:
  - mem_req=1 when state!=S_IDLE, redirect=0, and q_count+inflight < DEPTH.
  - mem_addr=fetch_pc (combinational from register).
  - On issue: fetch_pc+=4 (32-bit wrap, no overflow flag), and inflight=1 next cycle.
  - The occupancy check takes no credit for a same-cycle dequeue.
- Fill:
  - mem_valid=1 and not dropped: write {addr+4, mem_rdata} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - inflight clears on every mem_valid, dropped or not.
- Drain:
  - instr_valid = (q_count!=0) && redirect==0.
  - Head is popped when instr_valid && deq_ready.
  - Simultaneous push and pop: q_count unchanged, both pointers advance.
- Full: q_count==DEPTH blocks issue, so a response can never arrive into a full queue. An assertion flags a violation.
- Empty: instr_valid=0 and instr_out=0, so a stalled consumer loads a NOP.
- Redirect (highest priority, on its cycle):
  - Queue cleared and pointers reset; no pop takes effect.
  - fetch_pc=redirect_pc; no issue that cycle.
  - If inflight=1, next state is S_FLUSH.
  - First issue at redirect_pc happens on the following cycle.
- Redirect concurrent with rst=0: reset wins.
- redirect_pc[1:0] is ignored; address is forced word-aligned.
- Latency:
  - Request to instr_valid: 2 cycles (issue at N, data at N+1, visible at N+2).
  - Redirect to first valid target instruction: 3 cycles.

Optional Feature:
- Macro: PFQ_BYPASS_EN.
- With the macro defined: when the queue is empty, a non-dropped response, and deq_ready=1, the response drives instr_out/pc_out/instr_valid combinationally in the N+1 cycle and is not written. Request-to-valid latency becomes 1 cycle.
- Without the macro: every response is enqueued first; latency is 2 cycles; no combinational path from mem_rdata to instr_out.

Test Plan:
- Reset then free-run, deq_ready=1, mem_rdata=addr+32'h1000 → mem_addr 0,4,8,...; first instr_valid 2 cycles after first mem_req with instr_out=32'h1000, pc_out=4; one instruction per cycle thereafter.
- Hold deq_ready=0 from reset → exactly DEPTH(4) requests issued (addrs 0..12), q_count=4, mem_req=0 afterwards; release deq_ready → entries pop in order pc_out 4,8,12,16, and fetch resumes at 16.
- Redirect to 32'h0000_0100 while a request to 8 is in flight → response for 8 dropped, q_count=0 next cycle, mem_addr=0x100 on the following cycle, first valid pc_out=0x104.
- Assert redirect in the same cycle as deq_ready=1 with q_count=3 → instr_valid=0 that cycle, no pop, queue empty next cycle.
- Pull rst low for one cycle with q_count=2 and a request in flight → all outputs return to reset values; the in-flight response is not enqueued; fetch restarts at RESET_PC.
- With PFQ_BYPASS_EN defined and the queue empty → instr_valid rises in the same cycle as mem_valid, and q_count stays 0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word reads and buffers returned
// instructions tagged with PC+4 for IF/ID. Optional macro PFQ_BYPASS_EN adds an empty-queue bypass.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | first cycle after reset, nothing issued, responses dropped
// S_RUN   | normal fetch, responses enqueued (or bypassed)
// S_FLUSH | one cycle after a redirect that had a read in flight; response dropped
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_rdata,
    input  logic                     deq_ready,
    output logic                     instr_valid,
    output logic [31:0]              instr_out,
    output logic [31:0]              pc_out,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];

    logic          issue;
    logic          resp_ok;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW:0]   occupancy;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_RUN;
            default: state_nxt = (redirect && inflight) ? S_FLUSH : S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        occupancy  = {1'b0, q_count} + {{CW{1'b0}}, inflight};
        issue      = (state != S_IDLE) && !redirect && (occupancy < DEPTH_EXT);
        resp_ok    = mem_valid && (state == S_RUN) && !redirect;
        head_valid = (q_count != '0) && !redirect;
`ifdef PFQ_BYPASS_EN
        bypass     = resp_ok && deq_ready && (q_count == '0);
`else
        bypass     = 1'b0;
`endif
        push       = resp_ok && !bypass;
        pop        = head_valid && deq_ready;

        mem_req     = issue;
        mem_addr    = fetch_pc;
        instr_valid = head_valid || bypass;
        instr_out   = 32'd0;
        pc_out      = 32'd0;
        if (head_valid) begin
            instr_out = q_instr[rd_ptr];
            pc_out    = q_pc[rd_ptr];
        end else if (bypass) begin
            instr_out = mem_rdata;
            pc_out    = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            q_count  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue)          inflight <= 1'b1;
            else if (mem_valid) inflight <= 1'b0;

            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                q_count  <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push)  wr_ptr   <= wr_ptr + 1'b1;
                if (pop)   rd_ptr   <= rd_ptr + 1'b1;
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end

    // A response only lands one cycle after its issue with no redirect between,
    // so fetch_pc already holds that request's address + 4.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    full_write_a: assert property (@(posedge clk) disable iff (!rst)
                                   !(push && (q_count == FULL)));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios plus random traffic
// compared against an epoch-tagged queue model; honours PFQ_BYPASS_EN when defined.
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        deq_ready;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [2:0]  q_count;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .deq_ready   (deq_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder state (what the DUT actually requested)
    logic        rsp_req  = 1'b0;
    logic [31:0] rsp_addr = 32'd0;

    // reference model: each request carries the epoch it was issued in; redirect and reset
    // start a new epoch, and a response from an older epoch is discarded
    logic [63:0] mq[$];
    logic [31:0] m_pc       = 32'd0;
    int          m_since_rst = 0;
    bit          m_out      = 1'b0;
    bit          rsp_pend   = 1'b0;
    int          rsp_ep     = 0;
    logic [31:0] rsp_a      = 32'd0;
    int          epoch      = 0;

    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pc;
    logic [2:0]  e_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000;
    endfunction

    task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic dr);
        bit ok, byp;
        int sz;
        @(posedge clk);
        #1;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        deq_ready   = dr;
        mem_valid   = rsp_req;
        mem_rdata   = mem_word(rsp_addr);

        sz     = mq.size();
        e_req  = (m_since_rst != 0) && !rd && (sz + int'(m_out) < DEPTH);
        e_addr = m_pc;
        ok     = rsp_pend && (rsp_ep == epoch) && !rd;
        byp    = 1'b0;
`ifdef PFQ_BYPASS_EN
        byp    = ok && dr && (sz == 0);
`endif
        e_valid = !rd && ((sz > 0) || byp);
        e_instr = 32'd0;
        e_pc    = 32'd0;
        if (e_valid && sz > 0) begin
            e_pc    = mq[0][63:32];
            e_instr = mq[0][31:0];
        end else if (e_valid) begin
            e_pc    = rsp_a + 32'd4;
            e_instr = mem_word(rsp_a);
        end
        e_cnt = 3'(sz);

        if (!r) begin
            mq.delete();
            m_pc        = RESET_PC;
            epoch       = epoch + 1;
            m_since_rst = 0;
            m_out       = 1'b0;
        end else begin
            m_since_rst = m_since_rst + 1;
            m_out       = e_req;
            if (rd) begin
                mq.delete();
                m_pc  = rpc & 32'hFFFF_FFFC;
                epoch = epoch + 1;
            end else begin
                if (e_valid && dr && sz > 0) void'(mq.pop_front());
                if (ok && !byp) mq.push_back({rsp_a + 32'd4, mem_word(rsp_a)});
                if (e_req) m_pc = m_pc + 32'd4;
            end
        end
        rsp_pend = e_req;
        rsp_ep   = (r) ? epoch - (rd ? 1 : 0) : epoch - 1;
        rsp_a    = e_addr;

        @(negedge clk);
        rsp_req  = (mem_req === 1'b1);
        rsp_addr = mem_addr;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks += 6;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset.mem_req: got %b expected 0", mem_req); end
        if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset.mem_addr: got %h expected %h", mem_addr, RESET_PC); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset.instr_valid: got %b expected 0", instr_valid); end
        if (instr_out !== 32'd0) begin n_fail++; $display("FAIL reset.instr_out: got %h expected 0", instr_out); end
        if (pc_out !== 32'd0) begin n_fail++; $display("FAIL reset.pc_out: got %h expected 0", pc_out); end
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset.q_count: got %0d expected 0", q_count); end
    endtask

    task automatic test_free_run();
        bit exp_v;
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b1);
            exp_v = (k >= 1 + LAT);
            n_checks += 3;
            if (mem_req !== 1'b1) begin n_fail++; $display("FAIL free_run.mem_req k=%0d: got %b expected 1", k, mem_req); end
            if (mem_addr !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL free_run.mem_addr k=%0d: got %h expected %h", k, mem_addr, 32'(4 * (k - 1))); end
            if (instr_valid !== exp_v) begin n_fail++; $display("FAIL free_run.instr_valid k=%0d: got %b expected %b", k, instr_valid, exp_v); end
            if (exp_v) begin
                n_checks += 2;
                if (pc_out !== 32'(4 * (k - LAT))) begin n_fail++; $display("FAIL free_run.pc_out k=%0d: got %h expected %h", k, pc_out, 32'(4 * (k - LAT))); end
                if (instr_out !== 32'h1000 + 32'(4 * (k - LAT - 1))) begin n_fail++; $display("FAIL free_run.instr_out k=%0d: got %h expected %h", k, instr_out, 32'h1000 + 32'(4 * (k - LAT - 1))); end
            end
        end
    endtask

    task automatic test_stall_fill();
        int  nreq;
        bit  seen;
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            if (mem_req === 1'b1) begin
                n_checks++;
                if (mem_addr !== 32'(4 * nreq)) begin n_fail++; $display("FAIL stall.req_addr n=%0d: got %h expected %h", nreq, mem_addr, 32'(4 * nreq)); end
                nreq++;
            end
        end
        n_checks += 3;
        if (nreq != DEPTH) begin n_fail++; $display("FAIL stall.req_count: got %0d expected %0d", nreq, DEPTH); end
        if (q_count !== 3'd4) begin n_fail++; $display("FAIL stall.q_count: got %0d expected 4", q_count); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stall.mem_req_full: got %b expected 0", mem_req); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b1);
            n_checks += 2;
            if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drain.instr_valid i=%0d: got %b expected 1", i, instr_valid); end
            if (pc_out !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL drain.pc_out i=%0d: got %h expected %h", i, pc_out, 32'(4 * (i + 1))); end
            if (mem_req === 1'b1 && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (mem_addr !== 32'd16) begin n_fail++; $display("FAIL drain.resume_addr: got %h expected 00000010", mem_addr); end
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL drain.resume: got no request expected one at 00000010"); end
    endtask

    task automatic test_redirect_inflight();
        bit got;
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks++;
        if (mem_addr !== 32'd8) begin n_fail++; $display("FAIL redir.pre_addr: got %h expected 00000008", mem_addr); end
        cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        n_checks += 2;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir.valid_on_redirect: got %b expected 0", instr_valid); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL redir.req_on_redirect: got %b expected 0", mem_req); end
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks += 4;
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL redir.q_count: got %0d expected 0", q_count); end
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL redir.req_after: got %b expected 1", mem_req); end
        if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir.addr_after: got %h expected 00000100", mem_addr); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir.valid_flush: got %b expected 0", instr_valid); end
        got = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b1);
            if (instr_valid === 1'b1 && !got) begin
                got = 1'b1;
                n_checks += 3;
                if (pc_out !== 32'h104) begin n_fail++; $display("FAIL redir.first_pc: got %h expected 00000104", pc_out); end
                if (instr_out !== 32'h1100) begin n_fail++; $display("FAIL redir.first_instr: got %h expected 00001100", instr_out); end
                if (j + 2 != LAT + 1) begin n_fail++; $display("FAIL redir.latency: got %0d expected %0d", j + 2, LAT + 1); end
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL redir.timeout: got no valid expected pc 00000104"); end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0000_0202, 1'b1);
        n_checks += 3;
        if (q_count !== 3'd3) begin n_fail++; $display("FAIL redir_pop.q_before: got %0d expected 3", q_count); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_pop.valid: got %b expected 0", instr_valid); end
        if (instr_out !== 32'd0) begin n_fail++; $display("FAIL redir_pop.instr_out: got %h expected 0", instr_out); end
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        n_checks += 4;
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL redir_pop.q_after: got %0d expected 0", q_count); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_pop.valid_after: got %b expected 0", instr_valid); end
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL redir_pop.req_after: got %b expected 1", mem_req); end
        if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_pop.aligned_addr: got %h expected 00000200", mem_addr); end
    endtask

    task automatic test_reset_midop();
        bit got;
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        n_checks++;
        if (q_count !== 3'd2) begin n_fail++; $display("FAIL midrst.q_before: got %0d expected 2", q_count); end
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks += 6;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst.mem_req: got %b expected 0", mem_req); end
        if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst.mem_addr: got %h expected %h", mem_addr, RESET_PC); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst.instr_valid: got %b expected 0", instr_valid); end
        if (instr_out !== 32'd0) begin n_fail++; $display("FAIL midrst.instr_out: got %h expected 0", instr_out); end
        if (pc_out !== 32'd0) begin n_fail++; $display("FAIL midrst.pc_out: got %h expected 0", pc_out); end
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL midrst.q_count: got %0d expected 0", q_count); end
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks += 3;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst.restart_req: got %b expected 1", mem_req); end
        if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst.restart_addr: got %h expected %h", mem_addr, RESET_PC); end
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL midrst.dropped_resp: got q_count %0d expected 0", q_count); end
        got = 1'b0;
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b1);
            if (instr_valid === 1'b1 && !got) begin
                got = 1'b1;
                n_checks += 2;
                if (pc_out !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL midrst.first_pc: got %h expected %h", pc_out, RESET_PC + 32'd4); end
                if (instr_out !== mem_word(RESET_PC)) begin n_fail++; $display("FAIL midrst.first_instr: got %h expected %h", instr_out, mem_word(RESET_PC)); end
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL midrst.timeout: got no valid expected one"); end
    endtask

`ifdef PFQ_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        n_checks += 3;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bypass.instr_valid: got %b expected 1", instr_valid); end
        if (q_count !== 3'd0) begin n_fail++; $display("FAIL bypass.q_count: got %0d expected 0", q_count); end
        if (instr_out !== 32'h1000) begin n_fail++; $display("FAIL bypass.instr_out: got %h expected 00001000", instr_out); end
    endtask
`endif

    task automatic test_random();
        logic        r, rd, dr;
        logic [31:0] rpc;
        int          delivered;
        delivered = 0;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            r   = ($urandom_range(0, 99) != 0);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            dr  = (t % 200 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cyc(r, rd, rpc, dr);
            n_checks += 6;
            if (mem_req !== e_req) begin n_fail++; $display("FAIL random.mem_req t=%0d: got %b expected %b", t, mem_req, e_req); end
            if (mem_addr !== e_addr) begin n_fail++; $display("FAIL random.mem_addr t=%0d: got %h expected %h", t, mem_addr, e_addr); end
            if (instr_valid !== e_valid) begin n_fail++; $display("FAIL random.instr_valid t=%0d: got %b expected %b", t, instr_valid, e_valid); end
            if (instr_out !== e_instr) begin n_fail++; $display("FAIL random.instr_out t=%0d: got %h expected %h", t, instr_out, e_instr); end
            if (pc_out !== e_pc) begin n_fail++; $display("FAIL random.pc_out t=%0d: got %h expected %h", t, pc_out, e_pc); end
            if (q_count !== e_cnt) begin n_fail++; $display("FAIL random.q_count t=%0d: got %0d expected %0d", t, q_count, e_cnt); end
            if (instr_valid === 1'b1 && dr) delivered++;
        end
        n_checks++;
        if (delivered < 100) begin n_fail++; $display("FAIL random.throughput: got %0d deliveries expected at least 100", delivered); end
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_valid   = 1'b0;
        mem_rdata   = 32'd0;
        deq_ready   = 1'b0;
        test_reset();
        test_free_run();
        test_stall_fill();
        test_redirect_inflight();
        test_redirect_pop();
        test_reset_midop();
`ifdef PFQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
